// File: rtl/adder_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_arbiter_if
//  Description : Bundles the requester handshakes and the shared-adder bus
//                seen by adder_rr_arbiter.
//                slave  : the arbiter (drives grants, responses, adder operands)
//                master : the environment (clients plus the adder instance)
//  Ports       : req_valid/req_ready/req_a/req_b   request side, NUM_REQ lanes
//                rsp_valid/rsp_ready/rsp_sum       response side
//                add_a/add_b/add_sum               shared adder datapath
//                busy                              arbiter not idle
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_sum;
    logic                     busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_sum,
        output req_ready, rsp_valid, rsp_sum, add_a, add_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_sum,
        input  req_ready, rsp_valid, rsp_sum, add_a, add_b, busy
    );
endinterface
`default_nettype wire

// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_arbiter
//  Description : Round-robin arbiter sharing one registered adder among
//                NUM_REQ requesters, one operation in flight at a time.
//                IDLE grants, WAIT covers the adder latency, RESP holds the
//                result until the granted requester accepts it.
//  Ports       : clk   rising-edge clock
//                rstn  asynchronous active-low reset
//                bus   adder_rr_arbiter_if.slave (request, response, adder)
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int ADD_LATENCY = 1
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    adder_rr_arbiter_if.slave bus
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(ADD_LATENCY + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] w_req_ready;
    logic [GW-1:0]      w_pick;
    logic               w_found;
    logic [WIDTH-1:0]   w_req_a [NUM_REQ];
    logic [WIDTH-1:0]   w_req_b [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_a[gi] = bus.req_a[gi*WIDTH +: WIDTH];
        assign w_req_b[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end

    // Round-robin scan: lowest-priority position is the last requester served,
    // so the search starts one past it and wraps.
    always_comb begin : p_scan
        logic [GW-1:0] w_idx;
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin : p_next
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_valid_d  = rsp_valid_q;
        w_req_ready  = '0;
        case (state_q)
            S_IDLE: begin
                // A grant only exists when its valid is high, so ready here
                // is itself the handshake.
                if (w_found) begin
                    w_req_ready[w_pick] = 1'b1;
                    add_a_d = w_req_a[w_pick];
                    add_b_d = w_req_b[w_pick];
                    grant_d = w_pick;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Operands went out at the grant edge; the adder output is
                // valid ADD_LATENCY edges later, sampled one edge after that.
                if (cnt_q == CW'(ADD_LATENCY)) begin
                    rsp_sum_d            = bus.add_sum;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    rsp_valid_d  = '0;
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            rsp_sum_q    <= '0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Grant is combinational from req_valid, so gate it with reset directly.
    assign bus.req_ready = w_req_ready & {NUM_REQ{rstn}};
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
